// File: rtl/regbank_pkg.sv
// Shared constants and helpers for the register-bank write arbiter.
package regbank_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_NREQ  = 4;
    localparam int DEFAULT_DEPTH = 8;

    // Index width for a table of n entries; never narrower than one bit.
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/register.sv
// Single storage entry with write enable and an active-high asynchronous clear.
module register #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    // Hold unless the arbiter's winner targets this entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out <= '0;
        end else if (wr_en) begin
            out <= in;
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first eligible index at or after rr_ptr, wrapping.
module rr_arbiter
    import regbank_pkg::*;
#(
    parameter  int NREQ = DEFAULT_NREQ,
    localparam int PW   = addr_width(NREQ)
) (
    input  logic [NREQ-1:0] elig,
    input  logic [PW-1:0]   rr_ptr,
    output logic [NREQ-1:0] winner,
    output logic            valid
);

    // Rotating search; the first hit blocks all later candidates.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!valid && elig[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regbank_arbiter.sv
// Round-robin write arbiter in front of a small register bank, plus a registered read port.
module regbank_arbiter
    import regbank_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    parameter  int NREQ  = DEFAULT_NREQ,
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int AW    = addr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*AW-1:0]    req_addr,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       gnt,
    input  logic [AW-1:0]         rd_addr,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  busy
);

    localparam int PW = addr_width(NREQ);

    logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0]  elig;
    logic [NREQ-1:0]  win_onehot;
    logic             win_valid;
    logic [PW-1:0]    win_idx;
    logic [AW-1:0]    win_addr;
    logic [WIDTH-1:0] win_data;
    logic [DEPTH-1:0] wr_en;
    logic [WIDTH-1:0] entry [DEPTH];

    // A requester granted last cycle is masked so a held request is not committed twice.
    assign elig = req & ~gnt;

    rr_arbiter #(
        .NREQ(NREQ)
    ) u_rr_arbiter (
        .elig  (elig),
        .rr_ptr(rr_ptr_q),
        .winner(win_onehot),
        .valid (win_valid)
    );

    // Steer the winner's address/data and advance the pointer past it.
    always_comb begin
        win_idx  = '0;
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_onehot[i]) begin
                win_idx  = PW'(i);
                win_addr = req_addr[i*AW +: AW];
                win_data = req_data[i*WIDTH +: WIDTH];
            end
        end
        rr_ptr_d = rr_ptr_q;
        if (win_valid) begin
            rr_ptr_d = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
        end
    end

    // Address decode of the single committed write.
    always_comb begin
        wr_en = '0;
        for (int e = 0; e < DEPTH; e++) begin
            wr_en[e] = win_valid && (win_addr == AW'(e));
        end
    end

    for (genvar e = 0; e < DEPTH; e++) begin : g_entry
        register #(
            .WIDTH(WIDTH)
        ) u_entry (
            .clk  (clk),
            .rst  (~rst),
            .wr_en(wr_en[e]),
            .in   (win_data),
            .out  (entry[e])
        );
    end

    // Grant, contention flag, pointer and read data; same-edge read sees the pre-write value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt      <= '0;
            busy     <= 1'b0;
            rd_data  <= '0;
            rr_ptr_q <= '0;
        end else begin
            gnt      <= win_onehot;
            busy     <= ($countones(elig) > 1);
            rd_data  <= entry[rd_addr];
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule
